// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the fetch sequencer slice.
//   - DATA_W_DEF / BANK_AW_DEF : default memory word width and per-bank
//     address width used by fetch_seq_ctrl and fetch_parity.
//   - fetch_state_e            : sequencer state encoding.
//   - ST_* constants           : plain 3-bit copies of the encoding so the
//     state register can stay a simple logic vector in legacy tools.
// Optional feature macro honoured by the slice: PARITY_STOP_EN (enables the
// HALT state in fetch_seq_ctrl).

package fetch_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int BANK_AW_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUTPUT  = 3'd3,
        S_FINISH  = 3'd4,
        S_HALT    = 3'd5
    } fetch_state_e;

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_READ    = S_READ;
    localparam logic [2:0] ST_CAPTURE = S_CAPTURE;
    localparam logic [2:0] ST_OUTPUT  = S_OUTPUT;
    localparam logic [2:0] ST_FINISH  = S_FINISH;
    localparam logic [2:0] ST_HALT    = S_HALT;

endpackage

// File: rtl/fetch_parity.sv
// fetch_parity
// Purely combinational even-parity checker for one memory word.
// Ports:
//   data : input  [DATA_W-1:0]  word under test
//   ok   : output               1 when the word holds an even number of ones

module fetch_parity
    import fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    output logic              ok
);

    // The XOR reduction is 1 for an odd count of ones, so invert it.
    assign ok = ~(^data);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// Sweeps both memory banks (MEM1 then MEM2), one word at a time, presenting
// each word on a valid/ready output together with its sweep index and an
// even-parity verdict. Parity failures are counted per sweep.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : one-cycle pulse that starts a sweep (ignored while busy)
//   abort            : synchronous cancel, returns to IDLE from any active state
//   mem_rd_en        : read strobe, high only in READ
//   mem_bank         : bank select (0 = MEM1, 1 = MEM2)
//   mem_addr         : word address within the selected bank
//   mem_rdata        : read data, valid one cycle after mem_rd_en
//   out_valid        : fetched word available
//   out_ready        : consumer accepts the word
//   out_data         : fetched word
//   out_par_ok       : even-parity check of out_data passed
//   out_index        : sweep index {mem_bank, mem_addr}
//   busy             : high in every state except IDLE
//   done             : one-cycle pulse when a sweep completes normally
//   err_cnt          : saturating parity-failure count of current/last sweep
//
// Build option: define PARITY_STOP_EN to stop the sweep at the first parity
// failure (HALT state presents the failing word, then returns to IDLE
// without a done pulse). Without it failures are only counted.

module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BANK_AW = BANK_AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 mem_rd_en,
    output logic                 mem_bank,
    output logic [BANK_AW-1:0]   mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_par_ok,
    output logic [BANK_AW:0]     out_index,
    output logic                 busy,
    output logic                 done,
    output logic [BANK_AW+1:0]   err_cnt
);

    localparam int IDX_W = BANK_AW + 1;
    localparam int ERR_W = BANK_AW + 2;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [IDX_W-1:0]  index;
    logic [ERR_W-1:0]  err_q;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              par_ok;
    logic              active;
    logic              at_last;

    // Parity is evaluated on the raw read data so the verdict can be
    // registered in the same CAPTURE cycle as the word itself.
    fetch_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data (mem_rdata),
        .ok   (par_ok)
    );

    assign active  = (state != ST_IDLE);
    assign at_last = (index == LAST_IDX);

    // Next-state logic. Abort overrides whatever the state would otherwise
    // do, including a transfer happening in the same cycle: the consumer
    // still gets the word, but the sweep ends there.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef PARITY_STOP_EN
                if (!par_ok) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_OUTPUT;
                end
`else
                state_nxt = ST_OUTPUT;
`endif
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_nxt = at_last ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
`ifdef PARITY_STOP_EN
            ST_HALT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (active && abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // State, index, captured word and error counter. The index is only
    // advanced on a transfer that is not the last word and not aborted, so
    // it can never wrap into a second sweep. The error count survives an
    // abort and is only cleared by the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            index  <= '0;
            err_q  <= '0;
            data_q <= '0;
            par_q  <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == ST_IDLE) && start) begin
                index <= '0;
                err_q <= '0;
            end

            if (state == ST_CAPTURE) begin
                data_q <= mem_rdata;
                par_q  <= par_ok;
                if (!par_ok && (err_q != ERR_MAX)) begin
                    err_q <= err_q + ERR_W'(1);
                end
            end

            if ((state == ST_OUTPUT) && out_ready && !abort && !at_last) begin
                index <= index + IDX_W'(1);
            end
        end
    end

    // Memory side: the bank/address simply mirror the index register, which
    // stays constant from READ through the end of the transfer.
    assign mem_rd_en = (state == ST_READ);
    assign mem_bank  = index[IDX_W-1];
    assign mem_addr  = index[BANK_AW-1:0];

    // Consumer side. HALT never occurs unless PARITY_STOP_EN is defined.
    assign out_valid  = (state == ST_OUTPUT) || (state == ST_HALT);
    assign out_data   = data_q;
    assign out_par_ok = par_q;
    assign out_index  = index;
    assign busy       = active;
    assign done       = (state == ST_FINISH) && !abort;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl
// Directed bench for fetch_seq_ctrl: a vector table for the basic protocol
// plus hand-written multi-cycle sequences (full sweep, back-pressure stall,
// abort, mid-sweep reset, and parity stop when PARITY_STOP_EN is defined).

module tb_fetch_seq_ctrl;

    localparam int DATA_W  = 8;
    localparam int BANK_AW = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic                mem_rd_en;
    logic                mem_bank;
    logic [BANK_AW-1:0]  mem_addr;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_par_ok;
    logic [BANK_AW:0]    out_index;
    logic                busy;
    logic                done;
    logic [BANK_AW+1:0]  err_cnt;

    logic [7:0] mem1 [8];
    logic [7:0] mem2 [8];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       start;
        logic       abort;
        logic       ready;
        logic       valid;
        logic       busy;
        logic       done;
        logic       rd;
        logic       chk_idx;
        logic [3:0] idx;
        logic [4:0] err;
        logic       par;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    fetch_seq_ctrl #(
        .DATA_W  (DATA_W),
        .BANK_AW (BANK_AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mem_rd_en  (mem_rd_en),
        .mem_bank   (mem_bank),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_par_ok (out_par_ok),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done),
        .err_cnt    (err_cnt)
    );

    // Two-bank synchronous memory model: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem_bank ? mem2[mem_addr] : mem1[mem_addr];
        end
    end

    // Hard stop in case a sequence loses track of the DUT.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_word(input int idx);
        return (idx < 8) ? mem1[idx] : mem2[idx - 8];
    endfunction

    // Duplicated nibbles always give an even number of ones.
    task automatic fill_mem();
        for (int i = 0; i < 8; i++) begin
            mem1[i] = {4'(i), 4'(i)};
            mem2[i] = {4'(i + 8), 4'(i + 8)};
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive one table row, compare the outputs of the current cycle, and
    // advance to the next sampling point.
    task automatic apply_stimulus(input int n);
        logic [25:0] act;
        logic [25:0] exp;
        vec_t v;
        v         = vecs[n];
        start     = v.start;
        abort     = v.abort;
        out_ready = v.ready;
        #1;
        act = {out_valid, busy, done, mem_rd_en,
               v.rd ? {mem_bank, mem_addr} : 4'd0,
               v.chk_idx ? out_index : 4'd0,
               err_cnt,
               v.valid ? out_par_ok : 1'b0,
               v.valid ? out_data : 8'd0};
        exp = {v.valid, v.busy, v.done, v.rd,
               v.rd ? v.idx : 4'd0,
               v.chk_idx ? v.idx : 4'd0,
               v.err,
               v.valid ? v.par : 1'b0,
               v.valid ? v.data : 8'd0};
        check_output($sformatf("vec%0d", n), 32'(act), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int  t0;
        int  t1;
        int  xfers;
        int  dones;
        int  rds;
        bit  found;
        bit  pulsed;
        logic [4:0] exp_err;

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        fill_mem();
        @(negedge clk);

        // ---------------- reset values ----------------
        #1;
        check_output("reset_outputs",
                     32'({out_valid, mem_rd_en, busy, done, out_data, out_par_ok,
                          out_index, mem_bank, mem_addr, err_cnt}), 32'd0);
        do_reset();

`ifndef PARITY_STOP_EN
        // ---------------- vector table ----------------
        mem1[0] = 8'hD9;
        mem1[1] = 8'hAA;
        //           st    ab    rdy   val   busy  done  rd    chk   idx   err   par   data
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd1, 1'b0, 8'hD9};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 5'd1, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 1'b1, 8'hAA};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 5'd1, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd1, 1'b0, 8'hD9};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 8'h00};
        for (int n = 0; n < 14; n++) begin
            apply_stimulus(n);
        end
        start = 1'b0;
        abort = 1'b0;
`endif

        // ---------------- full sweep, ready tied high ----------------
        do_reset();
        fill_mem();
        pulse_start();
        t0 = -1; t1 = -1; xfers = 0; dones = 0; rds = 0;
        for (int c = 0; c < 120; c++) begin
            #1;
            if (mem_rd_en) begin
                if (t0 < 0) t0 = c;
                check_output("sweep_rd_addr", 32'({mem_bank, mem_addr}), 32'(rds));
                rds++;
            end
            if (out_valid && out_ready) begin
                check_output("sweep_index", 32'(out_index), 32'(xfers));
                check_output("sweep_data", 32'({out_par_ok, out_data}), 32'({1'b1, model_word(xfers)}));
                xfers++;
            end
            if (done) begin
                dones++;
                if (t1 < 0) t1 = c;
            end
            @(negedge clk);
            if (dones > 0 && !busy) break;
        end
        repeat (6) begin
            #1;
            if (done) dones++;
            if (mem_rd_en) rds++;
            @(negedge clk);
        end
        check_output("sweep_transfers", 32'(xfers), 32'd16);
        check_output("sweep_reads", 32'(rds), 32'd16);
        check_output("sweep_done_count", 32'(dones), 32'd1);
        check_output("sweep_cycles", 32'(t1 - t0), 32'd48);
        check_output("sweep_err_cnt", 32'(err_cnt), 32'd0);
        check_output("sweep_idle", 32'({busy, out_valid}), 32'd0);

        // ---------------- back-pressure stall at index 3 ----------------
        do_reset();
        fill_mem();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (out_valid && out_index == 4'd3) begin
                out_ready = 1'b0;
                found     = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("stall_reached", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("stall_hold%0d", k),
                         32'({out_valid, mem_rd_en, out_index, out_data}),
                         32'({1'b1, 1'b0, 4'd3, model_word(3)}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_output("stall_release", 32'({mem_rd_en, mem_bank, mem_addr, out_valid}),
                     32'({1'b1, 4'd4, 1'b0}));

        // ---------------- abort at index 9, start ignored while busy ----------------
        do_reset();
        fill_mem();
`ifndef PARITY_STOP_EN
        mem1[0] = 8'hD9;
        exp_err = 5'd1;
`else
        exp_err = 5'd0;
`endif
        pulse_start();
        found = 1'b0; pulsed = 1'b0; rds = 0;
        for (int c = 0; c < 80; c++) begin
            #1;
            start = 1'b0;
            if (mem_rd_en) begin
                rds++;
                if ({mem_bank, mem_addr} == 4'd9) begin
                    abort = 1'b1;
                    found = 1'b1;
                    break;
                end
                if ({mem_bank, mem_addr} == 4'd5 && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
            end
            @(negedge clk);
        end
        check_output("abort_reached", 32'(found), 32'd1);
        check_output("abort_read_seq", 32'(rds), 32'd10);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_output("abort_idle", 32'({busy, out_valid, done, mem_rd_en}), 32'd0);
        check_output("abort_err_kept", 32'(err_cnt), 32'(exp_err));
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done || busy) dones++;
        end
        check_output("abort_quiet", 32'(dones), 32'd0);

        // ---------------- reset asserted at index 5 ----------------
        do_reset();
        fill_mem();
`ifndef PARITY_STOP_EN
        mem1[0] = 8'hD9;
`endif
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (mem_rd_en && {mem_bank, mem_addr} == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("rst_reached", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check_output("rst_mid_sweep",
                     32'({out_valid, mem_rd_en, busy, done, out_data, out_par_ok,
                          out_index, mem_bank, mem_addr, err_cnt}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done || busy) dones++;
        end
        check_output("rst_quiet", 32'(dones), 32'd0);
        @(negedge clk);
        pulse_start();
        #1;
        check_output("rst_restart", 32'({mem_rd_en, mem_bank, mem_addr, err_cnt}),
                     32'({1'b1, 4'd0, 5'd0}));

`ifdef PARITY_STOP_EN
        // ---------------- parity stop at index 9 ----------------
        do_reset();
        fill_mem();
        mem2[1] = 8'h92;
        pulse_start();
        found = 1'b0; dones = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (done) dones++;
            if (out_valid && !out_par_ok) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("halt_reached", 32'(found), 32'd1);
        check_output("halt_state", 32'({busy, out_index, out_data, err_cnt}),
                     32'({1'b1, 4'd9, 8'h92, 5'd1}));
        @(negedge clk);
        #1;
        check_output("halt_exit", 32'({busy, out_valid, mem_rd_en}), 32'd0);
        repeat (4) begin
            if (done) dones++;
            @(negedge clk);
            #1;
        end
        check_output("halt_no_done", 32'(dones), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width.
REQ-002 SHALL have parameter BANK_AW, default 3, per-bank address width (8 words/bank, 2 banks).
REQ-003 SHALL have the following ports:
  clk  input  1  clock.
  reset  input  1  asynchronous, active-high reset.
  start  input  1  one-cycle pulse that begins a sweep.
  abort  input  1  synchronous cancel of the sweep.
  mem_rd_en  output  1  read strobe.
  mem_bank  output  1  bank select, 0=MEM1, 1=MEM2.
  mem_addr  output  BANK_AW  word address within the bank.
  mem_rdata  input  DATA_W  read data, valid 1 cycle after mem_rd_en.
  out_valid  output  1  fetched word available.
  out_ready  input  1  consumer accepts the word.
  out_data  output  DATA_W  fetched word.
  out_par_ok  output  1  even-parity check passed for out_data.
  out_index  output  BANK_AW+1  sweep index {mem_bank, mem_addr}.
  busy  output  1  high in any state except IDLE.
  done  output  1  one-cycle pulse at sweep end.
  err_cnt  output  BANK_AW+2  number of parity failures in the current/last sweep.

Function
REQ-004 SHALL implement FSM states IDLE, READ, CAPTURE, OUTPUT, FINISH (plus HALT with the macro, see Configuration).
REQ-005 IDLE: on start=1, SHALL clear index and err_cnt, then go to READ next cycle.
REQ-006 READ: SHALL assert mem_rd_en for exactly one cycle, with mem_bank=index[MSB] and mem_addr=index[BANK_AW-1:0], then go to CAPTURE.
REQ-007 CAPTURE: SHALL register mem_rdata into out_data, compute par_ok = (XOR of all bits == 0), and increment err_cnt (saturating) if par_ok=0; then go to OUTPUT.
REQ-008 OUTPUT: SHALL hold out_valid=1 with out_data, out_par_ok and out_index stable until out_ready=1; a transfer occurs when valid and ready are both 1.
REQ-009 On transfer, SHALL go to FINISH if index==2^(BANK_AW+1)-1, else increment index and go to READ.
REQ-010 Minimum issue-to-valid latency SHALL be 2 cycles (READ, CAPTURE); with out_ready tied high, throughput SHALL be one word per 3 cycles.
REQ-011 FINISH: SHALL pulse done=1 for one cycle and return to IDLE; index SHALL NOT wrap into a second sweep.
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with out_valid=0 and no done pulse; err_cnt SHALL be retained.
REQ-014 If abort and a transfer occur in the same cycle, the transfer SHALL complete and abort SHALL take precedence for the next state.
REQ-015 mem_rd_en SHALL be 0 in every state except READ.

Reset
REQ-016 On reset, SHALL enter IDLE with out_valid=0, mem_rd_en=0, busy=0, done=0, out_data=0, out_par_ok=0, out_index=0, mem_bank=0, mem_addr=0, err_cnt=0.
REQ-017 Reset asserted mid-sweep SHALL abandon the sweep immediately; no done pulse SHALL follow.

Configuration
REQ-018 With PARITY_STOP_EN defined, a parity failure SHALL move CAPTURE to HALT; HALT SHALL present the failing word (out_valid=1, out_par_ok=0) until transfer, then go to IDLE without done; busy SHALL stay high in HALT.
REQ-019 Without PARITY_STOP_EN, failures SHALL be counted only and the sweep SHALL continue.

Structure
REQ-020 Package fetch_pkg SHALL hold the state enum typedef and the DATA_W/BANK_AW defaults.
REQ-021 Parity SHALL be a sub-module fetch_parity (combinational data in, ok out), instantiated once.

Verification
REQ-022 MEM1[0]=0xD9, MEM1[1]=0xAA, out_ready=1, start -> word 0 out_par_ok=0, word 1 out_par_ok=1, err_cnt increments at index 0.
REQ-023 Full sweep, all words even parity, out_ready=1 -> 16 transfers, index 0..15, bank switches at 8, done pulse once, err_cnt=0, 48 cycles from READ to FINISH.
REQ-024 out_ready held 0 for 5 cycles at index 3 -> out_data/out_index stable; no mem_rd_en until the transfer.
REQ-025 abort at index 9 -> IDLE next cycle, out_valid=0, no done; start pulses while busy are ignored.
REQ-026 reset asserted at index 5 -> all outputs at reset values; a new start sweeps from index 0.
REQ-027 PARITY_STOP_EN defined, MEM2[1]=0x92 -> sweep halts at index 9 with out_par_ok=0, no done, returns to IDLE after the transfer.
